// File: rtl/riscv_hazard_controller.sv
// Hazard/stall sequencer for the 5-stage core. It covers the hazards the
// forwarding unit cannot resolve: load-use in D, multi-cycle MDU ops held in
// E (with a timeout), dmem wait in M, and branch-redirect flushes. It also
// keeps saturating counters of stall cycles and applied branch flushes.
module riscv_hazard_controller #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic             use_rs1_d,
  input  logic             use_rs2_d,
  input  logic [4:0]       rd_e,
  input  logic             mem_read_e,
  input  logic             branch_taken_e,
  input  logic             mdu_start_e,
  input  logic             mdu_done,
  input  logic             dmem_req_m,
  input  logic             dmem_ready,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic             flush_w,
  output logic             mdu_busy,
  output logic             mdu_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int              WC_W   = $clog2(MDU_TIMEOUT);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MDU_TIMEOUT - 1);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MDU_WAIT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            done_pending_q, done_pending_d;
  logic            mdu_timeout_q, mdu_timeout_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  logic mem_stall;
  logic load_use;
  logic branch_flush;

  assign mem_stall = dmem_req_m & ~dmem_ready;
  assign load_use  = mem_read_e & (rd_e != 5'd0) &
                     ((use_rs1_d & (rd_e == rs1_d)) | (use_rs2_d & (rd_e == rs2_d)));

  // Next-state, stall/flush decode and counter updates; dmem wait beats everything.
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    done_pending_d = done_pending_q;
    mdu_timeout_d  = mdu_timeout_q;
    stall_f = 1'b0; stall_d = 1'b0; stall_e = 1'b0; stall_m = 1'b0;
    flush_d = 1'b0; flush_e = 1'b0; flush_m = 1'b0; flush_w = 1'b0;
    branch_flush   = 1'b0;

    if (mem_stall) begin
      // Whole pipe frozen; W gets a bubble since M cannot retire.
      stall_f = 1'b1; stall_d = 1'b1; stall_e = 1'b1; stall_m = 1'b1;
      flush_w = 1'b1;
      if (state_q == ST_MDU_WAIT) begin
        // Remember a completion that arrives while frozen; keep timing the op
        // but hold at the limit so the abort lands once the freeze lifts.
        done_pending_d = done_pending_q | mdu_done;
        if (wait_cnt_q != WC_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end else if (state_q == ST_RUN) begin
      if (mdu_start_e) begin
        stall_f = 1'b1; stall_d = 1'b1; stall_e = 1'b1;
        flush_m = 1'b1;
        state_d        = ST_MDU_WAIT;
        wait_cnt_d     = '0;
        done_pending_d = 1'b0;
      end else if (branch_taken_e) begin
        // Wrong-path instrs in D and E are squashed; load-use on them is moot.
        flush_d      = 1'b1;
        flush_e      = 1'b1;
        branch_flush = 1'b1;
      end else if (load_use) begin
        stall_f = 1'b1; stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end else begin
      if (mdu_done | done_pending_q) begin
        // Result available: let the E op advance with no stall.
        state_d        = ST_RUN;
        done_pending_d = 1'b0;
      end else if (wait_cnt_q == WC_MAX) begin
        // Abort: drop the stuck op out of E, keep F/D so they re-present.
        stall_f = 1'b1; stall_d = 1'b1;
        flush_e = 1'b1; flush_m = 1'b1;
        state_d        = ST_RUN;
        wait_cnt_d     = '0;
        done_pending_d = 1'b0;
        mdu_timeout_d  = 1'b1;
      end else begin
        stall_f = 1'b1; stall_d = 1'b1; stall_e = 1'b1;
        flush_m = 1'b1;
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end

    stall_cycles_d = stall_cycles_q;
    if (stall_f && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
    flush_events_d = flush_events_q;
    if (branch_flush && (flush_events_q != '1)) flush_events_d = flush_events_q + 1'b1;

    // Nothing moves the pipe while reset is held.
    if (rst) begin
      stall_f = 1'b0; stall_d = 1'b0; stall_e = 1'b0; stall_m = 1'b0;
      flush_d = 1'b0; flush_e = 1'b0; flush_m = 1'b0; flush_w = 1'b0;
    end
  end

  // State, MDU tracking and perf counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      wait_cnt_q     <= '0;
      done_pending_q <= 1'b0;
      mdu_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      done_pending_q <= done_pending_d;
      mdu_timeout_q  <= mdu_timeout_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign mdu_busy     = (state_q == ST_MDU_WAIT);
  assign mdu_timeout  = mdu_timeout_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;

endmodule

// File: tb/tb_riscv_hazard_controller.sv
// Directed bench for riscv_hazard_controller (MDU_TIMEOUT=8, CNT_W=4).
// Control outputs are viewed as {stall_f,d,e,m, flush_d,e,m,w}.
module tb_riscv_hazard_controller;

  localparam int MDU_TIMEOUT = 8;
  localparam int CNT_W       = 4;

  localparam logic [7:0] C_NONE = 8'h00;
  localparam logic [7:0] C_MDU  = 8'hE2;  // stall f/d/e, flush m
  localparam logic [7:0] C_MEM  = 8'hF1;  // stall f/d/e/m, flush w
  localparam logic [7:0] C_LU   = 8'hC4;  // stall f/d, flush e
  localparam logic [7:0] C_BR   = 8'h0C;  // flush d/e
  localparam logic [7:0] C_ABRT = 8'hC6;  // stall f/d, flush e/m

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1_d, rs2_d, rd_e;
  logic use_rs1_d, use_rs2_d, mem_read_e, branch_taken_e, mdu_start_e, mdu_done;
  logic dmem_req_m, dmem_ready;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w;
  logic mdu_busy, mdu_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic [7:0] ctl;

  int n_checks = 0;
  int n_errors = 0;

  assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w};

  always #5 clk = ~clk;

  riscv_hazard_controller #(.MDU_TIMEOUT(MDU_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
    .rd_e(rd_e), .mem_read_e(mem_read_e), .branch_taken_e(branch_taken_e),
    .mdu_start_e(mdu_start_e), .mdu_done(mdu_done),
    .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .mdu_busy(mdu_busy), .mdu_timeout(mdu_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  task automatic clr_in();
    rs1_d = 5'd0; rs2_d = 5'd0; rd_e = 5'd0;
    use_rs1_d = 1'b0; use_rs2_d = 1'b0; mem_read_e = 1'b0;
    branch_taken_e = 1'b0; mdu_start_e = 1'b0; mdu_done = 1'b0;
    dmem_req_m = 1'b0; dmem_ready = 1'b0;
  endtask

  // Inputs change 1 after posedge, outputs are sampled 3 after posedge.
  task automatic settle();
    #2;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr_in();
    next_cyc(); next_cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr_in();
    mdu_start_e = 1'b1; dmem_req_m = 1'b1; branch_taken_e = 1'b1;
    settle();
    n_checks++;
    if (ctl !== C_NONE) begin n_errors++; $display("FAIL reset_ctl_during_rst got %h want %h", ctl, C_NONE); end
    next_cyc(); next_cyc();
    rst = 1'b0; clr_in(); settle();
    n_checks++;
    if ({mdu_busy, mdu_timeout, stall_cycles, flush_events, ctl} !== '0) begin
      n_errors++;
      $display("FAIL reset_state got busy=%b to=%b sc=%0d fe=%0d ctl=%h want all 0",
               mdu_busy, mdu_timeout, stall_cycles, flush_events, ctl);
    end
    next_cyc();
  endtask

  task automatic test_load_use();
    logic [4:0] rd_v [6] = '{5'd5, 5'd5, 5'd5, 5'd0, 5'd7, 5'd5};
    logic [4:0] r1_v [6] = '{5'd5, 5'd0, 5'd5, 5'd0, 5'd3, 5'd5};
    logic [4:0] r2_v [6] = '{5'd0, 5'd5, 5'd9, 5'd0, 5'd7, 5'd0};
    logic       u1_v [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       u2_v [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       mr_v [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] ex_v [6] = '{C_LU, C_LU, C_NONE, C_NONE, C_NONE, C_NONE};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      clr_in();
      rd_e = rd_v[i]; rs1_d = r1_v[i]; rs2_d = r2_v[i];
      use_rs1_d = u1_v[i]; use_rs2_d = u2_v[i]; mem_read_e = mr_v[i];
      settle();
      n_checks++;
      if (ctl !== ex_v[i]) begin n_errors++; $display("FAIL load_use[%0d] ctl got %h want %h", i, ctl, ex_v[i]); end
      next_cyc();
    end
    clr_in(); settle();
    n_checks++;
    if (stall_cycles !== 4'd2) begin n_errors++; $display("FAIL load_use_stall_cycles got %0d want 2", stall_cycles); end
    next_cyc();
  endtask

  task automatic test_mdu();
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      logic [7:0] exp_ctl;
      logic       exp_busy;
      clr_in();
      mdu_start_e = (c == 0);
      mdu_done    = (c == 4) || (c == 5);  // cyc5 pulse arrives in RUN: ignored
      exp_ctl  = (c <= 3) ? C_MDU : C_NONE;
      exp_busy = (c >= 1) && (c <= 4);
      settle();
      n_checks++;
      if (ctl !== exp_ctl || mdu_busy !== exp_busy) begin
        n_errors++;
        $display("FAIL mdu cyc%0d ctl/busy got %h/%b want %h/%b", c, ctl, mdu_busy, exp_ctl, exp_busy);
      end
      next_cyc();
    end
    clr_in(); settle();
    n_checks++;
    if (stall_cycles !== 4'd4) begin n_errors++; $display("FAIL mdu_stall_cycles got %0d want 4", stall_cycles); end
    next_cyc();
  endtask

  task automatic test_mdu_memstall();
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      logic [7:0] exp_ctl;
      logic       exp_busy;
      clr_in();
      mdu_start_e = (c == 0) || (c == 7);
      dmem_req_m  = (c >= 2) && (c <= 5);
      mdu_done    = (c == 3);
      if (c >= 2 && c <= 5) exp_ctl = C_MEM;
      else if (c == 6)      exp_ctl = C_NONE;
      else                  exp_ctl = C_MDU;   // cyc8: fresh op, stale done must not release it
      exp_busy = (c >= 1 && c <= 6) || (c == 8);
      settle();
      n_checks++;
      if (ctl !== exp_ctl || mdu_busy !== exp_busy) begin
        n_errors++;
        $display("FAIL mdu_memstall cyc%0d ctl/busy got %h/%b want %h/%b", c, ctl, mdu_busy, exp_ctl, exp_busy);
      end
      if (c == 7) begin
        n_checks++;
        if (stall_cycles !== 4'd6) begin n_errors++; $display("FAIL mdu_memstall_stall_cycles got %0d want 6", stall_cycles); end
      end
      next_cyc();
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      logic [7:0] exp_ctl;
      clr_in();
      mdu_start_e = (c == 0);
      mdu_done    = (c == 9);                  // late completion after abort
      if (c <= 7)      exp_ctl = C_MDU;
      else if (c == 8) exp_ctl = C_ABRT;
      else             exp_ctl = C_NONE;
      settle();
      n_checks++;
      if (ctl !== exp_ctl || mdu_busy !== (c >= 1 && c <= 8) || mdu_timeout !== (c >= 9)) begin
        n_errors++;
        $display("FAIL timeout cyc%0d ctl/busy/to got %h/%b/%b want %h/%b/%b", c, ctl, mdu_busy, mdu_timeout,
                 exp_ctl, (c >= 1 && c <= 8), (c >= 9));
      end
      next_cyc();
    end
    clr_in(); settle();
    n_checks++;
    if (stall_cycles !== 4'd9) begin n_errors++; $display("FAIL timeout_stall_cycles got %0d want 9", stall_cycles); end
    next_cyc();
  endtask

  task automatic test_timeout_deferred();
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      logic [7:0] exp_ctl;
      clr_in();
      mdu_start_e = (c == 0);
      dmem_req_m  = (c >= 6) && (c <= 10);
      if (c >= 6 && c <= 10) exp_ctl = C_MEM;
      else if (c == 11)      exp_ctl = C_ABRT;
      else if (c == 12)      exp_ctl = C_NONE;
      else                   exp_ctl = C_MDU;
      settle();
      n_checks++;
      if (ctl !== exp_ctl || mdu_timeout !== (c == 12)) begin
        n_errors++;
        $display("FAIL timeout_deferred cyc%0d ctl/to got %h/%b want %h/%b", c, ctl, mdu_timeout, exp_ctl, (c == 12));
      end
      next_cyc();
    end
  endtask

  task automatic test_mem_stall();
    do_reset();
    clr_in(); dmem_req_m = 1'b1; dmem_ready = 1'b1; settle();
    n_checks++;
    if (ctl !== C_NONE) begin n_errors++; $display("FAIL mem_ready_no_stall got %h want %h", ctl, C_NONE); end
    next_cyc();
    clr_in(); dmem_req_m = 1'b1; mdu_start_e = 1'b1; branch_taken_e = 1'b1;
    mem_read_e = 1'b1; rd_e = 5'd4; rs1_d = 5'd4; use_rs1_d = 1'b1; settle();
    n_checks++;
    if (ctl !== C_MEM) begin n_errors++; $display("FAIL mem_stall_priority got %h want %h", ctl, C_MEM); end
    next_cyc();
    clr_in(); settle();
    n_checks++;
    if (mdu_busy !== 1'b0 || flush_events !== 4'd0 || stall_cycles !== 4'd1) begin
      n_errors++;
      $display("FAIL mem_stall_ignored got busy=%b fe=%0d sc=%0d want 0/0/1", mdu_busy, flush_events, stall_cycles);
    end
    next_cyc();
  endtask

  task automatic test_branch();
    do_reset();
    clr_in(); branch_taken_e = 1'b1;
    mem_read_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5; use_rs1_d = 1'b1; settle();
    n_checks++;
    if (ctl !== C_BR) begin n_errors++; $display("FAIL branch_over_load_use got %h want %h", ctl, C_BR); end
    next_cyc();
    clr_in(); branch_taken_e = 1'b1; mdu_start_e = 1'b1; settle();
    n_checks++;
    if (ctl !== C_MDU || flush_events !== 4'd1) begin
      n_errors++; $display("FAIL branch_vs_mdu got ctl=%h fe=%0d want %h/1", ctl, flush_events, C_MDU);
    end
    next_cyc();
    clr_in(); branch_taken_e = 1'b1; mdu_done = 1'b1; settle();
    n_checks++;
    if (ctl !== C_NONE || mdu_busy !== 1'b1) begin
      n_errors++; $display("FAIL branch_in_mdu_wait got ctl=%h busy=%b want %h/1", ctl, mdu_busy, C_NONE);
    end
    next_cyc();
    clr_in(); settle();
    n_checks++;
    if (flush_events !== 4'd1 || mdu_busy !== 1'b0) begin
      n_errors++; $display("FAIL branch_flush_events got fe=%0d busy=%b want 1/0", flush_events, mdu_busy);
    end
    next_cyc();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      clr_in(); dmem_req_m = (c < 10); branch_taken_e = (c >= 10) || (c < 10);
      next_cyc();
    end
    for (int c = 0; c < 10; c++) begin
      clr_in(); branch_taken_e = 1'b1; next_cyc();
    end
    clr_in(); settle();
    n_checks++;
    if (stall_cycles !== 4'd10 || flush_events !== 4'hF) begin
      n_errors++; $display("FAIL saturation_a got sc=%0d fe=%0d want 10/15", stall_cycles, flush_events);
    end
    for (int c = 0; c < 8; c++) begin
      clr_in(); dmem_req_m = 1'b1; next_cyc();
    end
    clr_in(); settle();
    n_checks++;
    if (stall_cycles !== 4'hF || flush_events !== 4'hF) begin
      n_errors++; $display("FAIL saturation_b got sc=%0d fe=%0d want 15/15", stall_cycles, flush_events);
    end
    next_cyc();
  endtask

  task automatic test_rst_mid();
    do_reset();
    clr_in(); branch_taken_e = 1'b1; next_cyc();
    clr_in(); mdu_start_e = 1'b1; next_cyc();
    for (int c = 1; c <= 8; c++) begin clr_in(); next_cyc(); end  // aborts at cyc8
    for (int c = 0; c <= 3; c++) begin
      clr_in();
      mdu_start_e = (c == 0);
      if (c == 3) begin rst = 1'b1; dmem_req_m = 1'b1; end
      settle();
      if (c == 2) begin
        n_checks++;
        if (mdu_busy !== 1'b1 || mdu_timeout !== 1'b1 || flush_events !== 4'd1) begin
          n_errors++;
          $display("FAIL rst_mid_pre got busy=%b to=%b fe=%0d want 1/1/1", mdu_busy, mdu_timeout, flush_events);
        end
      end
      if (c == 3) begin
        n_checks++;
        if (ctl !== C_NONE) begin n_errors++; $display("FAIL rst_mid_ctl got %h want %h", ctl, C_NONE); end
      end
      next_cyc();
    end
    rst = 1'b0; clr_in(); settle();
    n_checks++;
    if ({mdu_busy, mdu_timeout, stall_cycles, flush_events, ctl} !== '0) begin
      n_errors++;
      $display("FAIL rst_mid_post got busy=%b to=%b sc=%0d fe=%0d ctl=%h want all 0",
               mdu_busy, mdu_timeout, stall_cycles, flush_events, ctl);
    end
    next_cyc();
  endtask

  initial begin
    rst = 1'b1; clr_in();
    #1;
    test_reset();
    test_load_use();
    test_mdu();
    test_mdu_memstall();
    test_timeout();
    test_timeout_deferred();
    test_mem_stall();
    test_branch();
    test_saturation();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
